// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared definitions for the PC redirect controller: FSM state codes, pending-kind enum, address width.
// The optional performance counters are enabled with PC_REDIRECT_PERF_EN.
`ifndef addrWidth
`define addrWidth 32
`endif

package pc_redirect_ctrl_pkg;

  localparam int ADDR_W_DEF = `addrWidth;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_BWAIT = 2'd1;
  localparam logic [1:0] ST_PEND  = 2'd2;

  typedef enum logic {
    KIND_JUMP   = 1'b0,
    KIND_BRANCH = 1'b1
  } pend_kind_t;

endpackage

// File: rtl/pc_redirect_ctrl_sat_counter32.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
// Instantiated by pc_redirect_ctrl only when PC_REDIRECT_PERF_EN is defined.
module sat_counter32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [31:0] count
);

  logic [31:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (inc && (count_reg != 32'hFFFF_FFFF)) begin
      count_reg <= count_reg + 32'd1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Steers PC redirects from decoder jumps and resolved branches, holding them while the pipeline stalls.
// Define PC_REDIRECT_PERF_EN to build the stall/redirect performance counters.
module pc_redirect_ctrl
  import pc_redirect_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_req,
  input  logic              dec_jump_valid,
  input  logic [ADDR_W-1:0] dec_jump_offset,
  input  logic              dec_branch,
  input  logic              br_resolve_valid,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_offset,
  output logic              pc_stall,
  output logic              pc_offset_valid,
  output logic [ADDR_W-1:0] pc_offset,
  output logic              branch_offset_valid,
  output logic [ADDR_W-1:0] branch_offset,
  output logic              ifid_flush,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_redirect_cnt
);

  logic [1:0]        state_reg, state_next;
  logic              pend_valid_reg, pend_valid_next;
  pend_kind_t        pend_kind_reg, pend_kind_next;
  logic [ADDR_W-1:0] pend_off_reg, pend_off_next;

  logic              stall_c;
  logic              jump_c;
  logic              branch_c;
  logic              flush_c;
  logic [ADDR_W-1:0] jump_off_c;
  logic [ADDR_W-1:0] branch_off_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_RUN;
      pend_valid_reg <= 1'b0;
      pend_kind_reg  <= KIND_JUMP;
      pend_off_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      pend_valid_reg <= pend_valid_next;
      pend_kind_reg  <= pend_kind_next;
      pend_off_reg   <= pend_off_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    pend_valid_next = pend_valid_reg;
    pend_kind_next  = pend_kind_reg;
    pend_off_next   = pend_off_reg;
    stall_c         = 1'b0;
    jump_c          = 1'b0;
    branch_c        = 1'b0;
    flush_c         = 1'b0;
    jump_off_c      = '0;
    branch_off_c    = '0;

    case (state_reg)
      ST_RUN: begin
        // A jump outranks a branch decoded in the same cycle; the branch is dropped.
        if (dec_jump_valid) begin
          if (!stall_req) begin
            jump_c     = 1'b1;
            jump_off_c = dec_jump_offset;
            flush_c    = 1'b1;
          end else begin
            pend_valid_next = 1'b1;
            pend_kind_next  = KIND_JUMP;
            pend_off_next   = dec_jump_offset;
            state_next      = ST_PEND;
          end
        end else if (dec_branch) begin
          stall_c    = 1'b1;
          state_next = ST_BWAIT;
        end
      end

      ST_BWAIT: begin
        if (!br_resolve_valid) begin
          stall_c = 1'b1;
        end else begin
          state_next = ST_RUN;
          if (br_taken) begin
            if (!stall_req) begin
              branch_c     = 1'b1;
              branch_off_c = br_offset;
              flush_c      = 1'b1;
            end else begin
              pend_valid_next = 1'b1;
              pend_kind_next  = KIND_BRANCH;
              pend_off_next   = br_offset;
              state_next      = ST_PEND;
            end
          end
        end
      end

      ST_PEND: begin
        if (!stall_req) begin
          if (pend_valid_reg) begin
            flush_c = 1'b1;
            if (pend_kind_reg == KIND_JUMP) begin
              jump_c     = 1'b1;
              jump_off_c = pend_off_reg;
            end else begin
              branch_c     = 1'b1;
              branch_off_c = pend_off_reg;
            end
          end
          pend_valid_next = 1'b0;
          pend_off_next   = '0;
          state_next      = ST_RUN;
        end
      end

      default: begin
        state_next      = ST_RUN;
        pend_valid_next = 1'b0;
      end
    endcase

    stall_c = stall_c | stall_req;
  end

  // Outputs are Mealy; reset must silence them immediately, not at the next edge.
  assign pc_stall            = stall_c & ~rst;
  assign pc_offset_valid     = jump_c & ~rst;
  assign pc_offset           = rst ? '0 : jump_off_c;
  assign branch_offset_valid = branch_c & ~rst;
  assign branch_offset       = rst ? '0 : branch_off_c;
  assign ifid_flush          = flush_c & ~rst;

`ifdef PC_REDIRECT_PERF_EN
  sat_counter32 u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (pc_stall),
    .count (perf_stall_cnt)
  );

  sat_counter32 u_redir_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (pc_offset_valid | branch_offset_valid),
    .count (perf_redirect_cnt)
  );
`else
  assign perf_stall_cnt    = 32'd0;
  assign perf_redirect_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Self-checking bench for pc_redirect_ctrl: directed vector table, reset corner cases, random vs. reference model.
// Counter checks follow PC_REDIRECT_PERF_EN.
module tb_pc_redirect_ctrl;

  typedef struct packed {
    logic        sr;
    logic        jv;
    logic [31:0] jo;
    logic        br;
    logic        rv;
    logic        tk;
    logic [31:0] bo;
  } in_t;

  typedef struct packed {
    logic        st;
    logic        pv;
    logic [31:0] po;
    logic        bv;
    logic [31:0] bo;
    logic        fl;
  } out_t;

  typedef struct {
    in_t  i;
    out_t e;
  } vec_t;

  typedef struct {
    bit          is_jump;
    logic [31:0] off;
  } pend_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_req = 1'b0;
  logic        dec_jump_valid = 1'b0;
  logic [31:0] dec_jump_offset = '0;
  logic        dec_branch = 1'b0;
  logic        br_resolve_valid = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_offset = '0;
  logic        pc_stall;
  logic        pc_offset_valid;
  logic [31:0] pc_offset;
  logic        branch_offset_valid;
  logic [31:0] branch_offset;
  logic        ifid_flush;
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_redirect_cnt;

  int tests = 0;
  int fails = 0;

  // Reference model: "waiting for a branch" flag plus a queue of deferred redirects.
  bit          m_wait = 1'b0;
  pend_t       m_q[$];
  logic [31:0] m_stalls = '0;
  logic [31:0] m_redirs = '0;

  vec_t vecs[24];

  pc_redirect_ctrl #(.ADDR_W(32)) u_dut (
    .clk                 (clk),
    .rst                 (rst),
    .stall_req           (stall_req),
    .dec_jump_valid      (dec_jump_valid),
    .dec_jump_offset     (dec_jump_offset),
    .dec_branch          (dec_branch),
    .br_resolve_valid    (br_resolve_valid),
    .br_taken            (br_taken),
    .br_offset           (br_offset),
    .pc_stall            (pc_stall),
    .pc_offset_valid     (pc_offset_valid),
    .pc_offset           (pc_offset),
    .branch_offset_valid (branch_offset_valid),
    .branch_offset       (branch_offset),
    .ifid_flush          (ifid_flush),
    .perf_stall_cnt      (perf_stall_cnt),
    .perf_redirect_cnt   (perf_redirect_cnt)
  );

  always #5 clk = ~clk;

  function automatic in_t mk_in(bit sr, bit jv, logic [31:0] jo, bit br, bit rv, bit tk, logic [31:0] bo);
    in_t r;
    r.sr = sr; r.jv = jv; r.jo = jo; r.br = br; r.rv = rv; r.tk = tk; r.bo = bo;
    return r;
  endfunction

  function automatic out_t mk_out(bit st, bit pv, logic [31:0] po, bit bv, logic [31:0] bo, bit fl);
    out_t r;
    r.st = st; r.pv = pv; r.po = po; r.bv = bv; r.bo = bo; r.fl = fl;
    return r;
  endfunction

  function automatic out_t sample_dut();
    return mk_out(pc_stall, pc_offset_valid, pc_offset, branch_offset_valid, branch_offset, ifid_flush);
  endfunction

  task automatic apply(input in_t i);
    stall_req        = i.sr;
    dec_jump_valid   = i.jv;
    dec_jump_offset  = i.jo;
    dec_branch       = i.br;
    br_resolve_valid = i.rv;
    br_taken         = i.tk;
    br_offset        = i.bo;
  endtask

  task automatic check(input string name, input out_t got, input out_t exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got st=%0b pv=%0b po=%h bv=%0b bo=%h fl=%0b, want st=%0b pv=%0b po=%h bv=%0b bo=%h fl=%0b",
               name, got.st, got.pv, got.po, got.bv, got.bo, got.fl,
               exp.st, exp.pv, exp.po, exp.bv, exp.bo, exp.fl);
    end else begin
      $display("[TB] %s ok st=%0b pv=%0b po=%h bv=%0b bo=%h fl=%0b",
               name, got.st, got.pv, got.po, got.bv, got.bo, got.fl);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, got, exp);
    end else begin
      $display("[TB] %s ok value=%h", name, got);
    end
  endtask

  // Expected outputs for one cycle, then advance the model as the clock edge would.
  task automatic model_step(input in_t i, output out_t o);
    pend_t p;
    o = '0;
    if (m_q.size() != 0) begin
      if (!i.sr) begin
        p = m_q.pop_front();
        o.fl = 1'b1;
        if (p.is_jump) begin o.pv = 1'b1; o.po = p.off; end
        else           begin o.bv = 1'b1; o.bo = p.off; end
      end
    end else if (m_wait) begin
      if (!i.rv) begin
        o.st = 1'b1;
      end else begin
        m_wait = 1'b0;
        if (i.tk) begin
          if (i.sr) begin
            p.is_jump = 1'b0; p.off = i.bo; m_q.push_back(p);
          end else begin
            o.bv = 1'b1; o.bo = i.bo; o.fl = 1'b1;
          end
        end
      end
    end else if (i.jv) begin
      if (i.sr) begin
        p.is_jump = 1'b1; p.off = i.jo; m_q.push_back(p);
      end else begin
        o.pv = 1'b1; o.po = i.jo; o.fl = 1'b1;
      end
    end else if (i.br) begin
      o.st   = 1'b1;
      m_wait = 1'b1;
    end
    if (i.sr) o.st = 1'b1;
    if (o.st && m_stalls != 32'hFFFF_FFFF) m_stalls = m_stalls + 32'd1;
    if ((o.pv || o.bv) && m_redirs != 32'hFFFF_FFFF) m_redirs = m_redirs + 32'd1;
  endtask

  function automatic void model_reset();
    m_wait = 1'b0;
    m_q.delete();
    m_stalls = '0;
    m_redirs = '0;
  endfunction

  // One clock cycle: drive just after posedge, compare at negedge where the PC consumes outputs.
  task automatic run_cycle(input string name, input in_t i, input bit use_tbl, input out_t tbl_exp);
    out_t mexp;
    apply(i);
    model_step(i, mexp);
    @(negedge clk);
    check(name, sample_dut(), use_tbl ? tbl_exp : mexp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    in_t  ri;
    out_t zero_o;
    zero_o = '0;

    vecs[0]  = '{mk_in(0,1,32'h10,0,0,0,0),        mk_out(0,1,32'h10,0,0,1)};
    vecs[1]  = '{mk_in(0,0,0,0,0,0,0),             mk_out(0,0,0,0,0,0)};
    vecs[2]  = '{mk_in(0,0,0,1,0,0,0),             mk_out(1,0,0,0,0,0)};
    vecs[3]  = '{mk_in(0,0,0,0,0,0,0),             mk_out(1,0,0,0,0,0)};
    vecs[4]  = '{mk_in(0,1,32'h55,0,0,0,0),        mk_out(1,0,0,0,0,0)};
    vecs[5]  = '{mk_in(0,0,0,0,0,0,0),             mk_out(1,0,0,0,0,0)};
    vecs[6]  = '{mk_in(0,0,0,0,1,1,32'hFFFF_FFF8), mk_out(0,0,0,1,32'hFFFF_FFF8,1)};
    vecs[7]  = '{mk_in(1,1,32'h20,0,0,0,0),        mk_out(1,0,0,0,0,0)};
    vecs[8]  = '{mk_in(1,0,0,0,0,0,0),             mk_out(1,0,0,0,0,0)};
    vecs[9]  = '{mk_in(1,0,0,1,0,0,0),             mk_out(1,0,0,0,0,0)};
    vecs[10] = '{mk_in(1,1,32'h99,0,0,0,0),        mk_out(1,0,0,0,0,0)};
    vecs[11] = '{mk_in(1,0,0,0,0,0,0),             mk_out(1,0,0,0,0,0)};
    vecs[12] = '{mk_in(0,0,0,0,0,0,0),             mk_out(0,1,32'h20,0,0,1)};
    vecs[13] = '{mk_in(0,1,32'h30,1,0,0,0),        mk_out(0,1,32'h30,0,0,1)};
    vecs[14] = '{mk_in(0,0,0,1,0,0,0),             mk_out(1,0,0,0,0,0)};
    vecs[15] = '{mk_in(0,0,0,0,1,0,32'h1234),      mk_out(0,0,0,0,0,0)};
    vecs[16] = '{mk_in(0,0,0,1,0,0,0),             mk_out(1,0,0,0,0,0)};
    vecs[17] = '{mk_in(1,0,0,0,1,1,32'h40),        mk_out(1,0,0,0,0,0)};
    vecs[18] = '{mk_in(0,0,0,1,0,0,0),             mk_out(0,0,0,1,32'h40,1)};
    vecs[19] = '{mk_in(0,0,0,1,0,0,0),             mk_out(1,0,0,0,0,0)};
    vecs[20] = '{mk_in(1,0,0,0,1,0,32'h77),        mk_out(1,0,0,0,0,0)};
    vecs[21] = '{mk_in(0,0,0,0,0,0,0),             mk_out(0,0,0,0,0,0)};
    vecs[22] = '{mk_in(1,0,0,0,0,0,0),             mk_out(1,0,0,0,0,0)};
    vecs[23] = '{mk_in(0,0,0,0,0,0,0),             mk_out(0,0,0,0,0,0)};

    // Reset held with a live jump request: everything must read zero.
    apply(mk_in(0,1,32'hAB,1,0,0,0));
    #3;
    check("reset_outputs", sample_dut(), zero_o);
    check32("reset_perf_stall", perf_stall_cnt, 32'd0);
    #9;
    rst = 1'b0;
    apply(mk_in(0,0,0,0,0,0,0));
    model_reset();
    @(posedge clk);
    #1;

    foreach (vecs[k]) begin
      run_cycle($sformatf("vec%0d", k), vecs[k].i, 1'b1, vecs[k].e);
    end

    // Reset pulse while a jump is pending: outputs drop at once and the jump is lost.
    run_cycle("pend_enter", mk_in(1,1,32'h77,0,0,0,0), 1'b1, mk_out(1,0,0,0,0,0));
    run_cycle("pend_hold", mk_in(1,0,0,0,0,0,0), 1'b1, mk_out(1,0,0,0,0,0));
    apply(mk_in(1,0,0,0,0,0,0));
    #2;
    rst = 1'b1;
    #1;
    check("rst_in_pend_stall", sample_dut(), zero_o);
    apply(mk_in(0,0,0,0,0,0,0));
    #1;
    check("rst_in_pend_release", sample_dut(), zero_o);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    run_cycle("post_rst_idle0", mk_in(0,0,0,0,0,0,0), 1'b1, zero_o);
    run_cycle("post_rst_idle1", mk_in(0,0,0,0,0,0,0), 1'b1, zero_o);
    run_cycle("post_rst_jump", mk_in(0,1,32'h8,0,0,0,0), 1'b1, mk_out(0,1,32'h8,0,0,1));

    for (int n = 0; n < 600; n++) begin
      ri.sr = ($urandom_range(0, 3) == 0);
      ri.jv = ($urandom_range(0, 5) == 0);
      ri.jo = $urandom;
      ri.br = ($urandom_range(0, 3) == 0);
      ri.rv = ($urandom_range(0, 2) == 0);
      ri.tk = $urandom_range(0, 1) == 1;
      ri.bo = $urandom;
      run_cycle($sformatf("rnd%0d", n), ri, 1'b0, zero_o);
    end

`ifdef PC_REDIRECT_PERF_EN
    check32("perf_stall_cnt", perf_stall_cnt, m_stalls);
    check32("perf_redirect_cnt", perf_redirect_cnt, m_redirs);
    @(negedge clk);
    force u_dut.u_stall_cnt.count_reg = 32'hFFFF_FFFD;
    @(posedge clk);
    #1;
    release u_dut.u_stall_cnt.count_reg;
    apply(mk_in(1,0,0,0,0,0,0));
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check32("perf_stall_saturate", perf_stall_cnt, 32'hFFFF_FFFF);
    apply(mk_in(0,0,0,0,0,0,0));
`else
    check32("perf_stall_tied", perf_stall_cnt, 32'd0);
    check32("perf_redirect_tied", perf_redirect_cnt, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_redirect_ctrl.md
PC_REDIRECT_CTRL -- requirements
Module: pc_redirect_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning PC/offset width (matches `addrWidth).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge; PC consumes outputs on falling edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port stall_req  input  1  external hold from staller.
REQ-005 SHALL have ports dec_jump_valid input 1 and dec_jump_offset input ADDR_W: unconditional PC-relative jump from decoder.
REQ-006 SHALL have port dec_branch  input  1  decoder issued a conditional branch.
REQ-007 SHALL have ports br_resolve_valid input 1, br_taken input 1, br_offset input ADDR_W: branch ALU result.
REQ-008 SHALL have ports pc_stall output 1, pc_offset_valid output 1, pc_offset output ADDR_W, branch_offset_valid output 1, branch_offset output ADDR_W: PC control.
REQ-009 SHALL have port ifid_flush  output 1  invalidate IF/ID entry.
REQ-010 SHALL have ports perf_stall_cnt output 32 and perf_redirect_cnt output 32.

Function
REQ-011 SHALL implement FSM states RUN, BWAIT, PEND.
REQ-012 RUN: dec_jump_valid and !stall_req SHALL drive pc_offset_valid=1, pc_offset=dec_jump_offset, ifid_flush=1 in the same cycle (zero latency).
REQ-013 RUN: dec_jump_valid with stall_req SHALL latch {kind=jump, offset} into the pending register, assert pc_stall, go PEND.
REQ-014 RUN: dec_branch (no jump) SHALL assert pc_stall combinationally that cycle and go BWAIT.
REQ-015 dec_jump_valid and dec_branch together SHALL honour the jump only; branch is dropped.
REQ-016 BWAIT: pc_stall=1 every cycle until br_resolve_valid; decoder inputs ignored.
REQ-017 BWAIT with br_resolve_valid, !stall_req: taken drives branch_offset_valid=1, branch_offset=br_offset, ifid_flush=1; not-taken drives pc_stall=0 only (PC+4); next state RUN.
REQ-018 BWAIT with br_resolve_valid and stall_req: taken latches {kind=branch, offset}, go PEND; not-taken go RUN with pc_stall held by stall_req.
REQ-019 PEND: pc_stall=1 while stall_req; in first cycle stall_req=0, issue pending redirect on the output matching its kind with ifid_flush=1, clear pending, go RUN.
REQ-020 PEND: new decoder/branch inputs SHALL be ignored.
REQ-021 pc_stall SHALL also be 1 whenever stall_req=1 in any state.
REQ-022 At most one of pc_offset_valid, branch_offset_valid SHALL be high per cycle; offsets SHALL be 0 when their valid is 0.
REQ-023 Offsets SHALL pass unmodified, ADDR_W wide, no sign extension performed.

Reset
REQ-024 rst SHALL asynchronously force RUN, clear pending register, and drive all outputs 0, including mid-BWAIT or mid-PEND.
REQ-025 First post-reset cycle SHALL behave as RUN with no pending redirect.

Configuration
REQ-026 With PC_REDIRECT_PERF_EN defined, perf_stall_cnt SHALL count cycles with pc_stall=1 and perf_redirect_cnt SHALL count issued redirects, both saturating at 32'hFFFF_FFFF, cleared by rst.
REQ-027 Without PC_REDIRECT_PERF_EN, both perf ports SHALL remain present and be tied to 0; no counter flops.

Structure
REQ-028 FSM state encoding and pending-kind enum SHALL live in the shared defines package; ADDR_W tied to `addrWidth.
REQ-029 Counters SHALL be one sub-module, sat_counter32, instantiated twice under the macro.

Verification
REQ-030 RUN, dec_jump_valid=1, offset=0x10, stall_req=0 -> same cycle pc_offset_valid=1, pc_offset=0x10, ifid_flush=1.
REQ-031 dec_branch=1, resolve taken offset=0xFFFFFFF8 after 3 cycles -> pc_stall=1 for 4 cycles, then branch_offset_valid=1, branch_offset=0xFFFFFFF8.
REQ-032 Jump offset=0x20 with stall_req=1 for 5 cycles -> pc_stall=1 5 cycles, then pc_offset_valid=1, pc_offset=0x20 in cycle 6.
REQ-033 BWAIT, resolve not-taken -> pc_stall=0, no valid asserted, ifid_flush=0, state RUN.
REQ-034 rst pulse during PEND -> all outputs 0 immediately, pending redirect never issued.
REQ-035 With PC_REDIRECT_PERF_EN, counter preloaded near saturation via 0xFFFFFFFF stall cycles (force) -> holds 0xFFFFFFFF.
